// File: rtl/fifo_scoreboard_checker.sv
// Shadow-FIFO checker for a sync FIFO: mirrors the DUT from its own wr_en/rd_en/data_in
// and flags per-cycle mismatches, with saturating pass/fail counters and first-error capture.
module fifo_scoreboard_checker #(
  parameter int FIFO_WIDTH  = 16,
  parameter int FIFO_DEPTH  = 8,
  parameter int CNT_W       = 16,
  parameter int STOP_ON_ERR = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [FIFO_WIDTH-1:0] data_in,
  input  logic [FIFO_WIDTH-1:0] data_out,
  input  logic                  wr_ack,
  input  logic                  overflow,
  input  logic                  underflow,
  input  logic                  full,
  input  logic                  empty,
  input  logic                  almostfull,
  input  logic                  almostempty,
  input  logic                  clear_cnt,
  output logic                  err_flag,
  output logic [7:0]            err_vec,
  output logic [7:0]            first_err_vec,
  output logic [CNT_W-1:0]      first_err_cyc,
  output logic [CNT_W-1:0]      error_count,
  output logic [CNT_W-1:0]      correct_count,
  output logic                  halted
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int OCC_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [OCC_W-1:0] OCC_FULL  = OCC_W'(FIFO_DEPTH);
  localparam logic [OCC_W-1:0] OCC_AFULL = OCC_W'(FIFO_DEPTH - 1);
  localparam logic [OCC_W-1:0] OCC_ONE   = OCC_W'(1);
  localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  typedef enum logic {S_ACTIVE = 1'b0, S_HALTED = 1'b1} state_t;

  logic [FIFO_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [FIFO_WIDTH-1:0] mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]      occ_q, occ_d;
  logic                  wr_ack_m_q, wr_ack_m_d;
  logic                  overflow_m_q, overflow_m_d;
  logic                  underflow_m_q, underflow_m_d;
  logic [FIFO_WIDTH-1:0] dout_m_q, dout_m_d;
  logic                  dv_m_q, dv_m_d;

  logic [CNT_W-1:0]      cycle_cnt_q, cycle_cnt_d;
  logic [CNT_W-1:0]      error_count_q, error_count_d;
  logic [CNT_W-1:0]      correct_count_q, correct_count_d;
  logic [CNT_W-1:0]      first_err_cyc_q, first_err_cyc_d;
  logic [7:0]            first_err_vec_q, first_err_vec_d;
  logic                  err_flag_q, err_flag_d;
  state_t                state_q, state_d;
  logic                  halted_q;

  logic full_m, empty_m, afull_m, aempty_m, wr_ok, rd_ok;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  assign full_m   = (occ_q == OCC_FULL);
  assign empty_m  = (occ_q == '0);
  assign afull_m  = (occ_q == OCC_AFULL);
  assign aempty_m = (occ_q == OCC_ONE);
  assign wr_ok    = wr_en && !full_m;
  assign rd_ok    = rd_en && !empty_m;

  // Shadow FIFO: keeps tracking even while halted so a later clear resumes in sync.
  always_comb begin
    mem_d         = mem_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    occ_d         = occ_q;
    dout_m_d      = dout_m_q;
    dv_m_d        = dv_m_q;
    wr_ack_m_d    = wr_ok;
    overflow_m_d  = wr_en && full_m;
    underflow_m_d = rd_en && empty_m;
    if (wr_ok) begin
      mem_d[wr_ptr_q] = data_in;
      wr_ptr_d        = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
    end
    if (rd_ok) begin
      dout_m_d = mem_q[rd_ptr_q];
      dv_m_d   = 1'b1;
      rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
    end
    if (wr_ok && !rd_ok) begin
      occ_d = occ_q + OCC_W'(1);
    end else if (rd_ok && !wr_ok) begin
      occ_d = occ_q - OCC_W'(1);
    end
  end

  always_comb begin
    err_vec    = '0;
    err_vec[0] = dv_m_q && (data_out != dout_m_q);
    err_vec[1] = (wr_ack != wr_ack_m_q);
    err_vec[2] = (overflow != overflow_m_q);
    err_vec[3] = (underflow != underflow_m_q);
    err_vec[4] = (full != full_m);
    err_vec[5] = (empty != empty_m);
    err_vec[6] = (almostfull != afull_m);
    err_vec[7] = (almostempty != aempty_m);
  end

  // A clearing cycle is neither counted nor allowed to record its own error.
  always_comb begin
    cycle_cnt_d     = cycle_cnt_q;
    error_count_d   = error_count_q;
    correct_count_d = correct_count_q;
    first_err_cyc_d = first_err_cyc_q;
    first_err_vec_d = first_err_vec_q;
    err_flag_d      = err_flag_q;
    state_d         = state_q;
    if (clear_cnt) begin
      cycle_cnt_d     = '0;
      error_count_d   = '0;
      correct_count_d = '0;
      first_err_cyc_d = '0;
      first_err_vec_d = '0;
      err_flag_d      = 1'b0;
      state_d         = S_ACTIVE;
    end else if (state_q == S_ACTIVE) begin
      cycle_cnt_d = sat_inc(cycle_cnt_q);
      if (|err_vec) begin
        error_count_d = sat_inc(error_count_q);
        if (!err_flag_q) begin
          first_err_vec_d = err_vec;
          first_err_cyc_d = cycle_cnt_q;
          err_flag_d      = 1'b1;
        end
        if (STOP_ON_ERR != 0) begin
          state_d = S_HALTED;
        end
      end else begin
        correct_count_d = sat_inc(correct_count_q);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      occ_q         <= '0;
      wr_ack_m_q    <= 1'b0;
      overflow_m_q  <= 1'b0;
      underflow_m_q <= 1'b0;
      dout_m_q      <= '0;
      dv_m_q        <= 1'b0;
    end else begin
      mem_q         <= mem_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      occ_q         <= occ_d;
      wr_ack_m_q    <= wr_ack_m_d;
      overflow_m_q  <= overflow_m_d;
      underflow_m_q <= underflow_m_d;
      dout_m_q      <= dout_m_d;
      dv_m_q        <= dv_m_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt_q     <= '0;
      error_count_q   <= '0;
      correct_count_q <= '0;
      first_err_cyc_q <= '0;
      first_err_vec_q <= '0;
      err_flag_q      <= 1'b0;
    end else begin
      cycle_cnt_q     <= cycle_cnt_d;
      error_count_q   <= error_count_d;
      correct_count_q <= correct_count_d;
      first_err_cyc_q <= first_err_cyc_d;
      first_err_vec_q <= first_err_vec_d;
      err_flag_q      <= err_flag_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_ACTIVE;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      halted_q <= (state_d == S_HALTED);
    end
  end

  assign err_flag      = err_flag_q;
  assign first_err_vec = first_err_vec_q;
  assign first_err_cyc = first_err_cyc_q;
  assign error_count   = error_count_q;
  assign correct_count = correct_count_q;
  assign halted        = halted_q;

endmodule

// File: tb/tb_fifo_scoreboard_checker.sv
// Drives two checkers (free-running 4-bit counters, and stop-on-error) from a queue-based
// ideal FIFO with optional fault injection; counters are predicted with plain arithmetic.
module tb_fifo_scoreboard_checker;
  localparam int W = 16;
  localparam int D = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         wr_en = 1'b0, rd_en = 1'b0, clear_cnt = 1'b0;
  logic [W-1:0] data_in = '0, data_out = '0;
  logic         wr_ack = 1'b0, overflow = 1'b0, underflow = 1'b0;
  logic         full = 1'b0, empty = 1'b1, almostfull = 1'b0, almostempty = 1'b0;

  logic         r_flag, r_halted;
  logic [7:0]   r_ev, r_fvec;
  logic [3:0]   r_fcyc, r_ecnt, r_ccnt;
  logic         s_flag, s_halted;
  logic [7:0]   s_ev, s_fvec;
  logic [15:0]  s_fcyc, s_ecnt, s_ccnt;

  always #5 clk = ~clk;

  fifo_scoreboard_checker #(.FIFO_WIDTH(W), .FIFO_DEPTH(D), .CNT_W(4), .STOP_ON_ERR(0)) u_run (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .rd_en(rd_en), .data_in(data_in), .data_out(data_out),
    .wr_ack(wr_ack), .overflow(overflow), .underflow(underflow), .full(full), .empty(empty),
    .almostfull(almostfull), .almostempty(almostempty), .clear_cnt(clear_cnt),
    .err_flag(r_flag), .err_vec(r_ev), .first_err_vec(r_fvec), .first_err_cyc(r_fcyc),
    .error_count(r_ecnt), .correct_count(r_ccnt), .halted(r_halted));

  fifo_scoreboard_checker #(.FIFO_WIDTH(W), .FIFO_DEPTH(D), .CNT_W(16), .STOP_ON_ERR(1)) u_stop (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .rd_en(rd_en), .data_in(data_in), .data_out(data_out),
    .wr_ack(wr_ack), .overflow(overflow), .underflow(underflow), .full(full), .empty(empty),
    .almostfull(almostfull), .almostempty(almostempty), .clear_cnt(clear_cnt),
    .err_flag(s_flag), .err_vec(s_ev), .first_err_vec(s_fvec), .first_err_cyc(s_fcyc),
    .error_count(s_ecnt), .correct_count(s_ccnt), .halted(s_halted));

  // Ideal FIFO standing in for a known-good DUT.
  logic [W-1:0] q[$];
  logic         g_ack, g_ovf, g_udf, g_dv;
  logic [W-1:0] g_dout;

  // Expected checker state, index 0 = u_run, 1 = u_stop.
  int   m_cyc[2], m_ec[2], m_cc[2], m_fc[2];
  logic [7:0] m_fv[2];
  bit   m_flag[2], m_halt[2];
  int   m_max[2]  = '{15, 65535};
  bit   m_stop[2] = '{1'b0, 1'b1};

  int    vectors = 0;
  int    miscompares = 0;
  string phase = "init";

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s/%s observed=%0h expected=%0h", phase, tag, obs, exp);
    end
  endtask

  task automatic check_regs();
    chk("run.err_flag",  32'(r_flag),   32'(m_flag[0]));
    chk("run.first_vec", 32'(r_fvec),   32'(m_fv[0]));
    chk("run.first_cyc", 32'(r_fcyc),   32'(m_fc[0]));
    chk("run.err_cnt",   32'(r_ecnt),   32'(m_ec[0]));
    chk("run.ok_cnt",    32'(r_ccnt),   32'(m_cc[0]));
    chk("run.halted",    32'(r_halted), 32'(m_halt[0]));
    chk("stop.err_flag", 32'(s_flag),   32'(m_flag[1]));
    chk("stop.first_vec",32'(s_fvec),   32'(m_fv[1]));
    chk("stop.first_cyc",32'(s_fcyc),   32'(m_fc[1]));
    chk("stop.err_cnt",  32'(s_ecnt),   32'(m_ec[1]));
    chk("stop.ok_cnt",   32'(s_ccnt),   32'(m_cc[1]));
    chk("stop.halted",   32'(s_halted), 32'(m_halt[1]));
  endtask

  function automatic int sat(input int v, input int mx);
    return (v >= mx) ? mx : v + 1;
  endfunction

  task automatic model_edge(input int i, input logic [7:0] ev, input bit clr);
    if (clr) begin
      m_cyc[i] = 0; m_ec[i] = 0; m_cc[i] = 0; m_fc[i] = 0; m_fv[i] = 8'h00;
      m_flag[i] = 1'b0; m_halt[i] = 1'b0;
    end else if (!m_halt[i]) begin
      if (ev != 8'h00) begin
        m_ec[i] = sat(m_ec[i], m_max[i]);
        if (!m_flag[i]) begin
          m_flag[i] = 1'b1; m_fv[i] = ev; m_fc[i] = m_cyc[i];
        end
        if (m_stop[i]) m_halt[i] = 1'b1;
      end else begin
        m_cc[i] = sat(m_cc[i], m_max[i]);
      end
      m_cyc[i] = sat(m_cyc[i], m_max[i]);
    end
  endtask

  task automatic drive_outs(input logic [7:0] inj, input logic [W-1:0] dbad);
    data_out    = inj[0] ? dbad : g_dout;
    wr_ack      = g_ack ^ inj[1];
    overflow    = g_ovf ^ inj[2];
    underflow   = g_udf ^ inj[3];
    full        = (q.size() == D) ^ inj[4];
    empty       = (q.size() == 0) ^ inj[5];
    almostfull  = (q.size() == D - 1) ^ inj[6];
    almostempty = (q.size() == 1) ^ inj[7];
  endtask

  task automatic golden_edge(input bit wr, input bit rd, input logic [W-1:0] din);
    bit f, e;
    f = (q.size() == D);
    e = (q.size() == 0);
    g_ack = wr && !f;
    g_ovf = wr && f;
    g_udf = rd && e;
    if (rd && !e) begin
      g_dout = q.pop_front();
      g_dv   = 1'b1;
    end
    if (wr && !f) q.push_back(din);
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic step(input bit wr, input bit rd, input logic [W-1:0] din,
                      input logic [7:0] inj, input logic [W-1:0] dbad, input bit clr);
    logic [7:0] ev;
    wr_en = wr; rd_en = rd; data_in = din; clear_cnt = clr;
    drive_outs(inj, dbad);
    ev = {inj[7:1], inj[0] & g_dv & (dbad != g_dout)};
    #1;
    chk("run.err_vec",  32'(r_ev), 32'(ev));
    chk("stop.err_vec", 32'(s_ev), 32'(ev));
    @(posedge clk);
    golden_edge(wr, rd, din);
    model_edge(0, ev, clr);
    model_edge(1, ev, clr);
    #1;
    check_regs();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_cnt = 1'b0;
    q.delete();
    g_ack = 1'b0; g_ovf = 1'b0; g_udf = 1'b0; g_dv = 1'b0; g_dout = '0;
    for (int i = 0; i < 2; i++) begin
      m_cyc[i] = 0; m_ec[i] = 0; m_cc[i] = 0; m_fc[i] = 0; m_fv[i] = 8'h00;
      m_flag[i] = 1'b0; m_halt[i] = 1'b0;
    end
    drive_outs(8'h00, '0);
    #1;
    chk("run.err_vec",  32'(r_ev), 32'h0);
    chk("stop.err_vec", 32'(s_ev), 32'h0);
    check_regs();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int pw, pr;
    @(negedge clk);
    phase = "reset";
    do_reset();

    phase = "underflow";
    step(0, 1, 16'h0, 8'h01, 16'hDEAD, 0);   // bad data_out ignored while nothing read yet
    step(0, 0, 16'h0, 8'h00, 16'h0, 0);

    phase = "fill";
    for (int i = 1; i <= 8; i++) step(1, 0, 16'(i), 8'h00, 16'h0, 0);
    step(1, 0, 16'h9, 8'h00, 16'h0, 0);      // write on full: overflow, no ack
    step(1, 1, 16'hA, 8'h00, 16'h0, 0);      // full + both: read only
    phase = "drain";
    while (q.size() > 3) step(0, 1, 16'h0, 8'h00, 16'h0, 0);
    step(1, 1, 16'h55, 8'h00, 16'h0, 0);     // count stays 3, oldest out
    step(0, 0, 16'h0, 8'h00, 16'h0, 0);

    phase = "halt";
    step(0, 0, 16'h0, 8'h00, 16'h0, 1);
    for (int i = 0; i < 5; i++) step(0, 0, 16'h0, 8'h00, 16'h0, 0);
    step(0, 0, 16'h0, 8'h01, 16'hDEAD, 0);
    chk("stop.first_vec_01", 32'(s_fvec),   32'h01);
    chk("stop.first_cyc_5",  32'(s_fcyc),   32'd5);
    chk("stop.halted_1",     32'(s_halted), 32'd1);
    chk("stop.err_cnt_1",    32'(s_ecnt),   32'd1);

    phase = "saturate";
    for (int i = 0; i < 18; i++) step(1, 1, 16'(i), 8'(1 << (i % 8)), 16'hBEEF, 0);
    step(0, 0, 16'h0, 8'h10, 16'h0, 1);      // error on clearing cycle is dropped
    for (int i = 0; i < 20; i++) step(0, 0, 16'h0, 8'h00, 16'h0, 0);

    phase = "random";
    for (int blk = 0; blk < 6; blk++) begin
      pw = (blk % 3 == 0) ? 75 : (blk % 3 == 1) ? 25 : 50;
      pr = 100 - pw;
      for (int i = 0; i < 60; i++) begin
        step($urandom_range(0, 99) < pw, $urandom_range(0, 99) < pr, 16'($urandom),
             ($urandom_range(0, 15) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00,
             16'($urandom), $urandom_range(0, 39) == 0);
      end
    end

    phase = "midreset";
    while (q.size() > 0) step(0, 1, 16'h0, 8'h00, 16'h0, 0);
    for (int i = 0; i < 5; i++) step(1, 0, 16'(16'h100 + i), 8'h00, 16'h0, 0);
    wr_en = 1'b1; data_in = 16'h1FF;
    do_reset();
    step(0, 0, 16'h0, 8'h20, 16'h0, 0);      // DUT claiming not-empty after reset
    step(1, 0, 16'h7, 8'h00, 16'h0, 0);
    step(0, 1, 16'h0, 8'h00, 16'h0, 0);
    step(0, 0, 16'h0, 8'h00, 16'h0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
